// File: rtl/audio_sched.sv
// Clk-domain sequencer for the guitar-filter sample path: ADC capture, IIR history,
// settle window for the combinational diffEq, and PWM duty handoff.
module audio_sched #(
  parameter int unsigned N          = 10,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned OVR_W      = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           audio_valid,
  input  logic [N-1:0]   audio_adc,
  input  logic           pot_valid,
  input  logic [2*N-1:0] pot_adc,
  input  logic           filt_type_in,
  input  logic [N-1:0]   iir_out,
  input  logic           pwm_ready,
  output logic [N-1:0]   x_cur,
  output logic [N-1:0]   x_prev,
  output logic [N-1:0]   y_prev,
  output logic           filt_type,
  output logic [N-1:0]   freq_adc,
  output logic [N-1:0]   duty_val,
  output logic           busy,
  output logic           sample_done,
  output logic [OVR_W-1:0] overrun_cnt
);

  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [N-1:0] MID = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             av_q, pv_q, pr_q;
  logic             audio_edge, pot_edge, pwm_edge;
  logic             pending, out_new, accept;
  logic [N-1:0]     pend_word, out_reg, sample;

  assign audio_edge = audio_valid & ~av_q;
  assign pot_edge   = pot_valid & ~pv_q;
  assign pwm_edge   = pwm_ready & ~pr_q;
  assign accept     = (state == IDLE) && (pending || audio_edge);
  assign sample     = pending ? pend_word : audio_adc;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETTLE;
      SETTLE:  if (cnt == '0) state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    sample_done = (state == CAPTURE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      av_q        <= 1'b1;
      pv_q        <= 1'b1;
      pr_q        <= 1'b1;
      x_cur       <= MID;
      x_prev      <= MID;
      y_prev      <= MID;
      duty_val    <= MID;
      out_reg     <= MID;
      filt_type   <= 1'b0;
      freq_adc    <= '0;
      overrun_cnt <= '0;
      pending     <= 1'b0;
      pend_word   <= '0;
      out_new     <= 1'b0;
      cnt         <= '0;
    end else begin
      av_q <= audio_valid;
      pv_q <= pot_valid;
      pr_q <= pwm_ready;

      case (state)
        IDLE: begin
          if (accept) begin
            x_cur <= sample;
            cnt   <= CNT_W'(SETTLE_CYC - 1);
            if (filt_type_in == filt_type) begin
              x_prev <= x_cur;
            end else begin
              filt_type <= filt_type_in;
              x_prev    <= MID;
              y_prev    <= MID;
            end
          end
          // A fresh edge while the pending word is consumed refills pending directly.
          if (pending) begin
            if (audio_edge) pend_word <= audio_adc;
            else            pending   <= 1'b0;
          end
        end
        SETTLE: if (cnt != '0) cnt <= cnt - CNT_W'(1);
        CAPTURE: begin
          out_reg <= iir_out;
          y_prev  <= iir_out;
        end
        default: ;
      endcase

      if ((state != IDLE) && audio_edge) begin
        pend_word <= audio_adc;
        pending   <= 1'b1;
        if (pending && (overrun_cnt != '1)) overrun_cnt <= overrun_cnt + OVR_W'(1);
      end

      // CAPTURE's out_new set is placed last so it wins over a coincident handoff.
      if (pwm_edge && out_new) begin
        duty_val <= out_reg;
        out_new  <= 1'b0;
      end
      if (state == CAPTURE) out_new <= 1'b1;

      if (pot_edge) freq_adc <= filt_type ? pot_adc[2*N-1:N] : pot_adc[N-1:0];
    end
  end

endmodule

// File: tb/tb_audio_sched.sv
// Directed self-checking bench for audio_sched (N=10, SETTLE_CYC=4, OVR_W=8).
module tb_audio_sched;
  localparam int unsigned N = 10;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           audio_valid;
  logic [N-1:0]   audio_adc;
  logic           pot_valid;
  logic [2*N-1:0] pot_adc;
  logic           filt_type_in;
  logic [N-1:0]   iir_out;
  logic           pwm_ready;
  logic [N-1:0]   x_cur, x_prev, y_prev, freq_adc, duty_val;
  logic           filt_type, busy, sample_done;
  logic [7:0]     overrun_cnt;

  int ncmp = 0;
  int nerr = 0;

  audio_sched #(.N(10), .SETTLE_CYC(4), .OVR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .audio_valid(audio_valid), .audio_adc(audio_adc),
    .pot_valid(pot_valid), .pot_adc(pot_adc), .filt_type_in(filt_type_in),
    .iir_out(iir_out), .pwm_ready(pwm_ready), .x_cur(x_cur), .x_prev(x_prev),
    .y_prev(y_prev), .filt_type(filt_type), .freq_adc(freq_adc), .duty_val(duty_val),
    .busy(busy), .sample_done(sample_done), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; audio_valid = 1'b0; audio_adc = '0; pot_valid = 1'b0;
    pot_adc = '0; filt_type_in = 1'b0; iir_out = 10'd700; pwm_ready = 1'b0;
    tick(); tick();
    chk("rst_x_cur", x_cur, 512);
    chk("rst_x_prev", x_prev, 512);
    chk("rst_y_prev", y_prev, 512);
    chk("rst_duty", duty_val, 512);
    chk("rst_busy", busy, 0);
    chk("rst_done", sample_done, 0);
    chk("rst_ovr", overrun_cnt, 0);
    chk("rst_freq", freq_adc, 0);
    chk("rst_ft", filt_type, 0);
    reset_n = 1'b1;
    tick();

    // Basic sample: accept, 4 settle cycles, capture, PWM handoff
    audio_adc = 10'd300; audio_valid = 1'b1;
    tick(); audio_valid = 1'b0;
    chk("t1_x_cur", x_cur, 300);
    chk("t1_x_prev", x_prev, 512);
    chk("t1_busy", busy, 1);
    tick(); tick(); tick();
    chk("t1_done_early", sample_done, 0);
    tick();
    chk("t1_done", sample_done, 1);
    tick();
    chk("t1_y_prev", y_prev, 700);
    chk("t1_done_off", sample_done, 0);
    chk("t1_busy_off", busy, 0);
    chk("t1_duty_hold", duty_val, 512);
    pwm_ready = 1'b1; tick(); pwm_ready = 1'b0;
    chk("t1_duty", duty_val, 700);
    tick();

    // Overrun: three edges during one busy window
    iir_out = 10'd600;
    audio_adc = 10'd10; audio_valid = 1'b1; tick(); audio_valid = 1'b0;
    chk("t2_x_cur1", x_cur, 10);
    chk("t2_x_prev1", x_prev, 300);
    tick();
    audio_adc = 10'd20; audio_valid = 1'b1; tick(); audio_valid = 1'b0; tick();
    audio_adc = 10'd30; audio_valid = 1'b1; tick(); audio_valid = 1'b0;
    chk("t2_ovr", overrun_cnt, 1);
    tick(); tick();
    chk("t2_x_cur3", x_cur, 30);
    chk("t2_x_prev3", x_prev, 10);
    repeat (6) tick();
    chk("t2_idle", busy, 0);
    chk("t2_ovr_final", overrun_cnt, 1);

    // Capture coincident with pwm_ready edge
    iir_out = 10'd250;
    audio_adc = 10'd40; audio_valid = 1'b1; tick(); audio_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t4_done", sample_done, 1);
    pwm_ready = 1'b1; tick(); pwm_ready = 1'b0;
    chk("t4_duty_old", duty_val, 600);
    chk("t4_y_prev", y_prev, 250);
    tick();
    pwm_ready = 1'b1; tick(); pwm_ready = 1'b0;
    chk("t4_duty_new", duty_val, 250);
    tick(); pwm_ready = 1'b1; tick(); pwm_ready = 1'b0; tick();
    pwm_ready = 1'b1; tick(); pwm_ready = 1'b0;
    chk("t4_duty_repeat", duty_val, 250);
    tick();

    // Pot select in LPF
    pot_adc = {10'd900, 10'd50}; pot_valid = 1'b1; tick(); pot_valid = 1'b0;
    chk("t5_freq_lpf", freq_adc, 50);
    tick();

    // Mode change flushes history
    filt_type_in = 1'b1; audio_adc = 10'd100; audio_valid = 1'b1; tick(); audio_valid = 1'b0;
    chk("t3_ft", filt_type, 1);
    chk("t3_x_prev", x_prev, 512);
    chk("t3_y_prev", y_prev, 512);
    chk("t3_x_cur", x_cur, 100);
    repeat (6) tick();

    pot_valid = 1'b1; tick(); pot_valid = 1'b0;
    chk("t5_freq_hpf", freq_adc, 900);
    tick();

    // Reset during SETTLE with audio_valid held high
    audio_adc = 10'd77; audio_valid = 1'b1; tick(); tick();
    chk("t6_busy_pre", busy, 1);
    reset_n = 1'b0; tick();
    chk("t6_x_cur", x_cur, 512);
    chk("t6_y_prev", y_prev, 512);
    chk("t6_duty", duty_val, 512);
    chk("t6_ft", filt_type, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", sample_done, 0);
    chk("t6_freq", freq_adc, 0);
    reset_n = 1'b1;
    repeat (6) begin
      tick();
      chk("t6_no_trigger", busy, 0);
    end
    chk("t6_x_cur_post", x_cur, 512);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
